// File: rtl/byteram_arbiter.sv
// Round-robin arbiter sharing one 1RW synchronous-read byteram among NReq requesters.
// Define BYTERAM_ARB_CLEAR_EN to zero-fill the whole RAM after reset before serving.
module byteram_arbiter #(
   parameter int AddrW = 10,
   parameter int NReq  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NReq-1:0]       req_valid,
   output logic [NReq-1:0]       req_ready,
   input  logic [NReq-1:0]       req_web,
   input  logic [NReq*AddrW-1:0] req_addr,
   input  logic [NReq*8-1:0]     req_wbyte,
   output logic [NReq-1:0]       rsp_valid,
   output logic [7:0]            rsp_byte,
   output logic                  init_done,
   output logic [AddrW-1:0]      ram_addr,
   output logic                  ram_web,
   output logic [7:0]            ram_ibyte,
   input  logic [7:0]            ram_obyte
);
   localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;

   logic [PtrW-1:0]  rr_ptr;
   logic [PtrW-1:0]  ptr_nxt;
   logic [PtrW-1:0]  idx;
   logic [NReq-1:0]  pend;
   logic [NReq-1:0]  sel;
   logic [AddrW-1:0] last_addr;
   logic [AddrW-1:0] clr_addr;
   logic [AddrW-1:0] addr_a [NReq];
   logic [7:0]       wbyte_a [NReq];
   logic [AddrW-1:0] gnt_addr;
   logic [7:0]       gnt_wbyte;
   logic             gnt_web;
   logic             found;
   logic             serving;
   logic             clearing;
   logic             handshake;
   int               scan;

`ifdef BYTERAM_ARB_CLEAR_EN
   // state   | meaning
   // S_CLEAR | writing 0 to address cnt, no grants
   // S_SERVE | round-robin service, terminal until reset
   typedef enum logic {S_CLEAR, S_SERVE} state_t;
   state_t           state, state_nxt;
   logic [AddrW-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_CLEAR) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == S_CLEAR && cnt == '1) state_nxt = S_SERVE;
   end

   // Gated by rstn so the RAM sees no write while reset is held.
   assign clearing  = (state == S_CLEAR) && rstn;
   assign serving   = (state == S_SERVE) && rstn;
   assign init_done = (state == S_SERVE);
   assign clr_addr  = cnt;
`else
   assign clearing  = 1'b0;
   assign serving   = rstn;
   assign init_done = 1'b1;
   assign clr_addr  = '0;
`endif

   always_comb begin
      for (int i = 0; i < NReq; i++) begin
         addr_a[i]  = req_addr[i*AddrW +: AddrW];
         wbyte_a[i] = req_wbyte[i*8 +: 8];
      end
   end

   // Scan from rr_ptr with wrap; first valid requester wins.
   always_comb begin
      found     = 1'b0;
      sel       = '0;
      idx       = '0;
      scan      = 0;
      ptr_nxt   = rr_ptr;
      gnt_addr  = '0;
      gnt_wbyte = '0;
      gnt_web   = 1'b1;
      for (int k = 0; k < NReq; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NReq) scan = scan - NReq;
         idx = PtrW'(scan);
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            sel[idx]  = 1'b1;
            gnt_addr  = addr_a[idx];
            gnt_wbyte = wbyte_a[idx];
            gnt_web   = req_web[idx];
            ptr_nxt   = (scan == NReq - 1) ? '0 : PtrW'(scan + 1);
         end
      end
   end

   assign handshake = serving && found;
   assign req_ready = serving ? sel : '0;

   always_comb begin
      ram_addr  = last_addr;
      ram_web   = 1'b1;
      ram_ibyte = '0;
      if (clearing) begin
         ram_addr = clr_addr;
         ram_web  = 1'b0;
      end else if (handshake) begin
         ram_addr  = gnt_addr;
         ram_web   = gnt_web;
         ram_ibyte = gnt_wbyte;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr    <= '0;
         pend      <= '0;
         last_addr <= '0;
      end else begin
         last_addr <= ram_addr;
         pend      <= (handshake && gnt_web) ? sel : '0;
         if (handshake) rr_ptr <= ptr_nxt;
      end
   end

   assign rsp_valid = pend;
   assign rsp_byte  = ram_obyte;
endmodule
